// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF-stage fetch controller.
package fetch_pkg;

    localparam int XLEN   = 32;
    localparam int JIDX_W = 26;

    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // MIPS j target: upper nibble of the delay-slot PC, index, word-aligned.
    function automatic logic [XLEN-1:0] jump_target(
        input logic [XLEN-1:0]   pc4,
        input logic [JIDX_W-1:0] index
    );
        return {pc4[XLEN-1:XLEN-4], index, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_controller_next_pc_sel.sv
// Combinational next-PC / IF-ID control selection for the fetch controller.
module next_pc_sel
    import fetch_pkg::*;
(
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   pc_plus4_i,
    input  logic [XLEN-1:0]   if_id_pc4_i,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [XLEN-1:0]   branch_target_i,
    input  logic              jump_i,
    input  logic [JIDX_W-1:0] jump_index_i,
    input  logic              in_range_i,
    input  state_t            state_i,
    output logic [XLEN-1:0]   next_pc_o,
    output logic              load_o,
    output logic              flush_o,
    output state_t            next_state_o
);

    logic            redirect;
    logic [XLEN-1:0] raw_target;
    logic [XLEN-1:0] target;

    assign redirect   = branch_taken_i | jump_i;
    assign raw_target = branch_taken_i ? branch_target_i
                                       : jump_target(if_id_pc4_i, jump_index_i);
    assign target     = {raw_target[XLEN-1:2], 2'b00};

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        next_pc_o    = pc_i;
        load_o       = 1'b0;
        flush_o      = 1'b0;
        next_state_o = state_i;

        if (!stall_i) begin
            if (redirect) begin
                next_pc_o    = target;
                flush_o      = 1'b1;
                next_state_o = ST_RUN;
            end else if (state_i == ST_RUN) begin
                if (!in_range_i) begin
                    flush_o      = 1'b1;
                    next_state_o = ST_HALT;
                end else begin
                    next_pc_o = pc_plus4_i;
                    load_o    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// IF-stage sequencer: owns the PC, drives imem, and registers the IF/ID stage.
module fetch_controller #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 64,
    parameter logic [31:0] NOP_WORD  = fetch_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    import fetch_pkg::state_t;
    import fetch_pkg::ST_RUN;
    import fetch_pkg::ST_HALT;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] if_id_instr_q;
    logic [31:0] if_id_pc4_q;
    logic        if_id_valid_q;
    logic        halted_q;
    logic [31:0] fetch_count_q;
    logic        in_range;
    logic        load;
    logic        flush;

    assign pc_plus4 = pc_q + 32'd4;
    assign in_range = (pc_q >> 2) < 32'(MEM_WORDS);

    next_pc_sel u_next_pc_sel (
        .pc_i            (pc_q),
        .pc_plus4_i      (pc_plus4),
        .if_id_pc4_i     (if_id_pc4_q),
        .stall_i         (stall),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .jump_i          (jump),
        .jump_index_i    (jump_index),
        .in_range_i      (in_range),
        .state_i         (state_q),
        .next_pc_o       (pc_d),
        .load_o          (load),
        .flush_o         (flush),
        .next_state_o    (state_d)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            if_id_instr_q <= NOP_WORD;
            if_id_pc4_q   <= 32'd0;
            if_id_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= (state_d == ST_HALT);
            // if_id_pc4 keeps its last value across a flush so a later j still sees it.
            if (flush) begin
                if_id_instr_q <= NOP_WORD;
                if_id_valid_q <= 1'b0;
            end else if (load) begin
                if_id_instr_q <= imem_instr;
                if_id_pc4_q   <= pc_plus4;
                if_id_valid_q <= 1'b1;
                fetch_count_q <= fetch_count_q + 32'd1;
            end
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc4   = if_id_pc4_q;
    assign if_id_valid = if_id_valid_q;
    assign halted      = halted_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: a reference model queues expectations per edge.
module tb_fetch_controller;

    localparam int MEM_W = 42;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        halt;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_halt;
    logic [31:0] m_cnt;

    int n_cmp;
    int n_bad;

    fetch_controller #(
        .RESET_PC  (32'h0000_0000),
        .MEM_WORDS (MEM_W),
        .NOP_WORD  (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .pc            (pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Distinct, never-zero word per address so a bubble can't be mistaken for a fetch.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {8'hA5, a[23:0]} ^ 32'h0013_5700;
    endfunction

    assign imem_instr = imem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic st, input logic br,
                              input logic [31:0] bt, input logic j, input logic [25:0] ji);
        logic [31:0] tgt;
        tgt = br ? {bt[31:2], 2'b00} : {m_pc4[31:28], ji, 2'b00};
        if (rst) begin
            m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0;
            m_valid = 1'b0; m_halt = 1'b0; m_cnt = 32'd0;
        end else if (st) begin
            // everything holds
        end else if (br || j) begin
            m_pc = tgt; m_instr = 32'd0; m_valid = 1'b0; m_halt = 1'b0;
        end else if (!m_halt) begin
            if ((m_pc >> 2) >= MEM_W) begin
                m_instr = 32'd0; m_valid = 1'b0; m_halt = 1'b1;
            end else begin
                m_instr = imem_word(m_pc);
                m_pc4   = m_pc + 32'd4;
                m_pc    = m_pc + 32'd4;
                m_valid = 1'b1;
                m_cnt   = m_cnt + 32'd1;
            end
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic br,
                        input logic [31:0] bt, input logic j, input logic [25:0] ji);
        exp_t e;
        reset = rst; stall = st; branch_taken = br; branch_target = bt;
        jump = j; jump_index = ji;
        model_edge(rst, st, br, bt, j, ji);
        e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4;
        e.valid = m_valid; e.halt = m_halt; e.cnt = m_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("sb_pc",    pc,                   e.pc);
        check("sb_addr",  imem_addr,            e.pc);
        check("sb_instr", if_id_instr,          e.instr);
        check("sb_pc4",   if_id_pc4,            e.pc4);
        check("sb_valid", 32'(if_id_valid),     32'(e.valid));
        check("sb_halt",  32'(halted),          32'(e.halt));
        check("sb_count", fetch_count,          e.cnt);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        m_pc = '0; m_instr = '0; m_pc4 = '0; m_valid = 1'b0; m_halt = 1'b0; m_cnt = '0;
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_index = '0;

        // Reset state and four clean fetches.
        do_reset();
        check("rst_pc",    pc,                 32'd0);
        check("rst_instr", if_id_instr,        32'd0);
        check("rst_valid", 32'(if_id_valid),   32'd0);
        check("rst_count", fetch_count,        32'd0);
        run(4);
        check("fetch4_pc",    pc,              32'd16);
        check("fetch4_pc4",   if_id_pc4,       32'd16);
        check("fetch4_instr", if_id_instr,     imem_word(32'd12));
        check("fetch4_valid", 32'(if_id_valid), 32'd1);
        check("fetch4_count", fetch_count,     32'd4);

        // Two-cycle stall at pc=8, with a redirect request that must be ignored.
        do_reset();
        run(2);
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0);
        step(1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 26'd0);
        check("stall_pc",    pc,               32'd8);
        check("stall_instr", if_id_instr,      imem_word(32'd4));
        check("stall_count", fetch_count,      32'd2);
        run(1);
        check("unstall_pc",  pc,               32'd12);

        // Taken branch at pc=0x30, then the word at the target.
        do_reset();
        run(12);
        check("pre_br_pc", pc, 32'h30);
        step(1'b0, 1'b0, 1'b1, 32'h78, 1'b0, 26'd0);
        check("br_pc",    pc,                  32'h78);
        check("br_valid", 32'(if_id_valid),    32'd0);
        check("br_instr", if_id_instr,         32'd0);
        run(1);
        check("br_fetch", if_id_instr,         imem_word(32'h78));

        // Branch beats jump (target low bits cleared), then jump alone.
        do_reset();
        run(30);
        check("pre_j_pc4", if_id_pc4, 32'h78);
        step(1'b0, 1'b0, 1'b1, 32'h43, 1'b1, 26'h17);
        check("br_wins_pc", pc, 32'h40);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 26'h17);
        check("jump_pc", pc, 32'h5C);

        // Run off the end of the program and halt.
        for (int i = 0; i < 64 && !halted; i++) run(1);
        check("halt_reached", 32'(halted), 32'd1);
        check("halt_pc",      pc,          32'hA8);
        run(3);
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 26'h3F);
        check("halt_hold_pc",    pc,              32'hA8);
        check("halt_hold_valid", 32'(if_id_valid), 32'd0);

        // Jump out of HALT to an out-of-range target: RUN for one edge, then halt again.
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 26'h3F);
        check("unhalt_pc",   pc,          32'hFC);
        check("unhalt_flag", 32'(halted), 32'd0);
        run(1);
        check("rehalt_flag", 32'(halted), 32'd1);
        check("rehalt_pc",   pc,          32'hFC);

        // Reset wins over a stall and over a redirect.
        do_reset();
        run(8);
        check("pre_rst_pc", pc, 32'h20);
        step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0);
        check("rst_stall_pc",    pc,              32'd0);
        check("rst_stall_valid", 32'(if_id_valid), 32'd0);
        check("rst_stall_count", fetch_count,     32'd0);
        run(3);
        step(1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 26'h10);
        check("rst_redir_pc",    pc,              32'd0);
        check("rst_redir_count", fetch_count,     32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
